// File: rtl/sdm_pkg.sv
// Shared definitions for the MASH sigma-delta modulator and its decimating receiver.
package sdm_pkg;

  localparam int SDM_OUT_W = 4;

  typedef logic signed [SDM_OUT_W-1:0] sdm_sample_t;

  typedef enum logic {
    CIC_INTEG = 1'b0,
    CIC_COMB  = 1'b1
  } cic_mode_e;

  // Register growth of an N-stage CIC with differential delay 1 is N*log2(R) bits.
  function automatic int cic_bw(input int in_w, input int n, input int r_log2);
    return in_w + n * r_log2;
  endfunction

endpackage

// File: rtl/cic_stage.sv
// One BW-bit CIC section: a registered integrator or a differential-delay-1 comb.
module cic_stage
  import sdm_pkg::*;
#(
  parameter int        BW        = 20,
  parameter cic_mode_e MODE      = CIC_INTEG,
  parameter bit        LOOKAHEAD = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [BW-1:0] din,
  output logic [BW-1:0] y
);

  logic [BW-1:0] q;
  logic [BW-1:0] sum;
  logic [BW-1:0] diff;

  // Modulo-2^BW arithmetic; wrap is what keeps the CIC exact.
  always_comb begin
    sum  = q + din;
    diff = din - q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= (MODE == CIC_COMB) ? din : sum;
    end
  end

  // The last integrator feeds the combs its post-update value, hence LOOKAHEAD.
  always_comb begin
    if (MODE == CIC_COMB) begin
      y = diff;
    end else if (LOOKAHEAD) begin
      y = sum;
    end else begin
      y = q;
    end
  end

endmodule

// File: rtl/sdm_decim.sv
// sinc^N decimator for the 4-bit MASH output stream. Define SDM_DECIM_ROUND_EN for
// round-half-up output with saturation and a sticky ovf flag (default: truncation).
module sdm_decim
  import sdm_pkg::*;
#(
  parameter int W      = 16,
  parameter int R_LOG2 = 4,
  parameter int N      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SDM_OUT_W-1:0] sdm_in,
  input  logic                 sdm_vld,
  output logic [W-1:0]         dout,
  output logic                 dout_vld,
  output logic                 ovf
);

  localparam int BW = cic_bw(SDM_OUT_W, N, R_LOG2);

  if (BW < W) begin : g_bw_check
    $error("sdm_decim: internal width BW=%0d is narrower than output width W=%0d", BW, W);
  end

  sdm_sample_t         sample;
  logic [BW-1:0]       integ [0:N];
  logic [BW-1:0]       comb  [0:N];
  logic [R_LOG2-1:0]   cnt;
  logic                strobe;
  logic [W-1:0]        scaled;

  assign sample   = sdm_sample_t'(sdm_in);
  assign integ[0] = {{(BW - SDM_OUT_W){sample[SDM_OUT_W-1]}}, sample};
  assign comb[0]  = integ[N];
  assign strobe   = sdm_vld && (cnt == '1);

  for (genvar k = 1; k <= N; k++) begin : g_integ
    cic_stage #(
      .BW        (BW),
      .MODE      (CIC_INTEG),
      .LOOKAHEAD (k == N)
    ) u_integ (
      .clk (clk),
      .rst (rst),
      .en  (sdm_vld),
      .din (integ[k-1]),
      .y   (integ[k])
    );
  end

  for (genvar k = 1; k <= N; k++) begin : g_comb
    cic_stage #(
      .BW        (BW),
      .MODE      (CIC_COMB),
      .LOOKAHEAD (1'b0)
    ) u_comb (
      .clk (clk),
      .rst (rst),
      .en  (strobe),
      .din (comb[k-1]),
      .y   (comb[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (sdm_vld) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef SDM_DECIM_ROUND_EN
  localparam int          RND_SH = (BW > W) ? (BW - W - 1) : 0;
  localparam logic [BW:0] RND    = (BW > W) ? ((BW + 1)'(1) << RND_SH) : '0;

  logic [BW:0] rsum;
  logic        sat;

  // A carry into the sign bit can only happen on the positive side.
  always_comb begin
    rsum   = {comb[N][BW-1], comb[N]} + RND;
    sat    = rsum[BW] != rsum[BW-1];
    scaled = sat ? {1'b0, {(W - 1){1'b1}}} : rsum[BW-1:BW-W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (strobe && sat) begin
      ovf <= 1'b1;
    end
  end
`else
  assign scaled = comb[N][BW-1:BW-W];
  assign ovf    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= strobe;
      if (strobe) begin
        dout <= scaled;
      end
    end
  end

endmodule

// File: tb/tb_sdm_decim.sv
// Randomised bench for sdm_decim against a direct-convolution sinc^N reference model.
module tb_sdm_decim;

  localparam int W      = 16;
  localparam int R_LOG2 = 4;
  localparam int N      = 4;
  localparam int R      = 1 << R_LOG2;
  localparam int BW     = 4 + N * R_LOG2;
  localparam int HLEN   = N * (R - 1) + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   sdm_in = '0;
  logic         sdm_vld = 1'b0;
  logic [W-1:0] dout;
  logic         dout_vld;
  logic         ovf;

  always #5 clk = ~clk;

  sdm_decim #(
    .W      (W),
    .R_LOG2 (R_LOG2),
    .N      (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sdm_in   (sdm_in),
    .sdm_vld  (sdm_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .ovf      (ovf)
  );

  int    total = 0;
  int    bad   = 0;
  longint h [HLEN];
  int    hist [$];
  int    exp_dout = 0;
  bit    exp_vld  = 1'b0;
  bit    exp_ovf  = 1'b0;
  int    cyc      = 0;

  // Impulse response of N cascaded length-R boxcars.
  function automatic void build_h();
    longint a [HLEN];
    longint b [HLEN];
    int len = 1;
    foreach (a[i]) a[i] = 0;
    a[0] = 1;
    for (int s = 0; s < N; s++) begin
      foreach (b[i]) b[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++)
          b[i+j] += a[i];
      a = b;
      len += R - 1;
    end
    h = a;
  endfunction

  // The filtered value always fits BW bits, so the wrapped DUT result equals the exact sum.
  function automatic void model_out();
    longint acc = 0;
    int n = hist.size() - 1;
    for (int k = 0; k < HLEN; k++) begin
      int idx = n - (N - 1) - k;
      if (idx >= 0) acc += h[k] * longint'(hist[idx]);
    end
`ifdef SDM_DECIM_ROUND_EN
    acc += longint'(1) << (BW - W - 1);
    if (acc > (longint'(1) << (BW - 1)) - 1) begin
      exp_dout = (1 << (W - 1)) - 1;
      exp_ovf  = 1'b1;
    end else begin
      exp_dout = int'(acc >>> (BW - W));
    end
`else
    exp_dout = int'(acc >>> (BW - W));
`endif
  endfunction

  task automatic step(input bit r, input bit v, input int x);
    rst     = r;
    sdm_vld = v;
    sdm_in  = x[3:0];
    @(posedge clk);
    cyc++;
    if (r) begin
      hist.delete();
      exp_dout = 0;
      exp_vld  = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      exp_vld = 1'b0;
      if (v) begin
        hist.push_back(x);
        if (hist.size() % R == 0) begin
          model_out();
          exp_vld = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 5);
    step(1'b1, 1'b0, 0);
    total++;
    if (dout !== '0) begin
      bad++; $display("FAIL reset_dout: got %0h, want 0", dout);
    end
    total++;
    if (dout_vld !== 1'b0) begin
      bad++; $display("FAIL reset_vld: got %b, want 0", dout_vld);
    end
    total++;
    if (ovf !== 1'b0) begin
      bad++; $display("FAIL reset_ovf: got %b, want 0", ovf);
    end
  endtask

  task automatic test_constant(input int x, input int steady, input bit gaps);
    int pulses = 0;
    int last   = -1;
    int period = gaps ? 2 * R : R;
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 8 * period; i++) begin
      step(1'b0, gaps ? ((i % 2) == 0) : 1'b1, x);
      total++;
      if (dout_vld !== exp_vld || int'($signed(dout)) !== exp_dout || ovf !== exp_ovf) begin
        bad++;
        $display("FAIL const_model x=%0d cyc=%0d: got vld=%b dout=%0d ovf=%b, want vld=%b dout=%0d ovf=%b",
                 x, cyc, dout_vld, $signed(dout), ovf, exp_vld, exp_dout, exp_ovf);
      end
      if (dout_vld === 1'b1) begin
        pulses++;
        if (last >= 0) begin
          total++;
          if (i - last !== period) begin
            bad++; $display("FAIL const_period x=%0d: got %0d, want %0d", x, i - last, period);
          end
        end
        last = i;
        if (pulses >= 5) begin
          total++;
          if (int'($signed(dout)) !== steady || ovf !== 1'b0) begin
            bad++;
            $display("FAIL const_steady x=%0d: got dout=%0d ovf=%b, want dout=%0d ovf=0",
                     x, $signed(dout), ovf, steady);
          end
        end
      end
    end
    total++;
    if (pulses !== 8) begin
      bad++; $display("FAIL const_pulses x=%0d: got %0d, want 8", x, pulses);
    end
  endtask

  task automatic test_midframe_reset();
    int nvalid = 0;
    bit seen   = 1'b0;
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < R + 7; i++) step(1'b0, 1'b1, int'($urandom_range(15)) - 8);
    step(1'b1, 1'b1, 7);
    total++;
    if (dout !== '0 || dout_vld !== 1'b0) begin
      bad++; $display("FAIL midreset_clear: got dout=%0h vld=%b, want dout=0 vld=0", dout, dout_vld);
    end
    for (int i = 0; i < 200 && !seen; i++) begin
      bit v = ($urandom_range(3) != 0);
      step(1'b0, v, int'($urandom_range(15)) - 8);
      if (v) nvalid++;
      total++;
      if (dout_vld !== exp_vld || int'($signed(dout)) !== exp_dout) begin
        bad++;
        $display("FAIL midreset_model cyc=%0d: got vld=%b dout=%0d, want vld=%b dout=%0d",
                 cyc, dout_vld, $signed(dout), exp_vld, exp_dout);
      end
      if (dout_vld === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || nvalid !== R) begin
      bad++; $display("FAIL midreset_latency: got seen=%b after %0d valid, want %0d", seen, nvalid, R);
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 20000; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0) ? 3 : -3);
      total++;
      if (dout_vld !== exp_vld || int'($signed(dout)) !== exp_dout || ovf !== exp_ovf) begin
        bad++;
        $display("FAIL wrap_model cyc=%0d: got vld=%b dout=%0d ovf=%b, want vld=%b dout=%0d ovf=%b",
                 cyc, dout_vld, $signed(dout), ovf, exp_vld, exp_dout, exp_ovf);
      end
      if (dout_vld === 1'b1) begin
        pulses++;
        if (pulses >= 5) begin
          total++;
          if (dout !== '0) begin
            bad++; $display("FAIL wrap_steady cyc=%0d: got %0h, want 0", cyc, dout);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(999) == 0), ($urandom_range(3) != 0), int'($urandom_range(15)) - 8);
      total++;
      if (dout_vld !== exp_vld || int'($signed(dout)) !== exp_dout || ovf !== exp_ovf) begin
        bad++;
        $display("FAIL random_model cyc=%0d: got vld=%b dout=%0d ovf=%b, want vld=%b dout=%0d ovf=%b",
                 cyc, dout_vld, $signed(dout), ovf, exp_vld, exp_dout, exp_ovf);
      end
    end
  endtask

  initial begin
    build_h();
    test_reset();
    test_constant(1, 4096, 1'b0);
    test_constant(-4, -16384, 1'b0);
    test_constant(3, 12288, 1'b0);
    test_constant(2, 8192, 1'b1);
    test_midframe_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
